// File: rtl/lsu_data_port_if.sv
// -----------------------------------------------------------------------------
// lsu_data_port_if
//
// Word-addressed data-memory handshake between the LSU (master) and the
// data memory / bus fabric (slave).
//
//   mem_req    master->slave  request, held until mem_ack
//   mem_we     master->slave  1 = write
//   mem_addr   master->slave  word-aligned byte address
//   mem_wdata  master->slave  lane-aligned store data
//   mem_wstrb  master->slave  byte enables, 0000 on reads
//   mem_ack    slave->master  access completes this cycle
//   mem_rdata  slave->master  read word, valid with mem_ack on reads
// -----------------------------------------------------------------------------
interface lsu_data_port_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_data_port.sv
// -----------------------------------------------------------------------------
// lsu_data_port
//
// MEM-stage load/store unit. Accepts one memory op per request, runs a single
// word access on the data bus, lane-aligns stores with byte strobes and returns
// sign/zero-extended load data for the writeback mux. Misaligned, illegal and
// (optionally) timed-out accesses complete with err/err_code for the trap unit.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only when idle)
//   is_load, is_store   op type; store wins if both are set
//   funct3              RV32 width/sign (B, H, W, BU, HU)
//   addr, store_data    byte address, rs2 value
//   mem                 data bus, master side of lsu_data_port_if
//   done                one-cycle completion pulse
//   load_rdata          extended load result, valid with done
//   err, err_code       fault flag with done; 1 misaligned, 2 illegal, 3 timeout
//
// Optional feature: define LSU_TIMEOUT_EN to enable the bus watchdog, which
// abandons an access after TIMEOUT_CYCLES un-acked bus cycles (err_code 3).
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module lsu_data_port #(
  parameter int          DATA_WIDTH     = `DATA_WIDTH, // only 32 is supported
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  lsu_data_port_if.master       mem,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] load_rdata,
  output logic                  err,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [31:0]     maddr_q, maddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lane_q, lane_d;
  logic [1:0]      code_q, code_d;
  logic [31:0]     rdata_q, rdata_d;

`ifdef LSU_TIMEOUT_EN
  logic [7:0]      wd_q, wd_d;
`else
  logic            unused_timeout;
  assign unused_timeout = ^TO_LIMIT;
`endif

  logic            op_store;
  logic            illegal;
  logic            misaligned;
  logic [31:0]     shifted;
  logic [31:0]     ext_data;
  logic [31:0]     lane_wdata;
  logic [3:0]      lane_wstrb;

  // Store wins when both op flags are set.
  assign op_store = is_store;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (op_store) begin
      illegal = (funct3 >= 3'b011);
    end else begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    // funct3[1:0] encodes access size for every legal code (B/BU, H/HU, W).
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Replicate store data into every lane; strobes pick the live bytes.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        lane_wdata = {4{store_data[7:0]}};
        lane_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{store_data[15:0]}};
        lane_wstrb = 4'b0011 << addr[1:0];
      end
      default: begin
        lane_wdata = store_data;
        lane_wstrb = 4'b1111;
      end
    endcase
  end

  // Bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    shifted = mem.mem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext_data = {24'd0, shifted[7:0]};
      3'b101:  ext_data = {16'd0, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    code_d  = code_q;
    rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && (is_load || is_store)) begin
          if (illegal) begin
            code_d  = 2'd2;
            rdata_d = '0;
            state_d = RESP;
          end else if (misaligned) begin
            code_d  = 2'd1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            we_d    = op_store;
            maddr_d = {addr[31:2], 2'b00};
            wdata_d = op_store ? lane_wdata : 32'd0;
            wstrb_d = op_store ? lane_wstrb : 4'b0000;
            f3_d    = funct3;
            lane_d  = addr[1:0];
            code_d  = 2'd0;
`ifdef LSU_TIMEOUT_EN
            wd_d    = 8'd0;
`endif
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // An ack in the watchdog's final cycle still completes normally.
        if (mem.mem_ack) begin
          rdata_d = we_q ? 32'd0 : ext_data;
          state_d = RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else if (wd_q == TO_LIMIT) begin
          code_d  = 2'd3;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      code_q  <= '0;
      rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      code_q  <= code_d;
      rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  // mem_req decodes straight from the state flop so reset drops it at once.
  assign req_ready     = (state_q == IDLE);
  assign done          = (state_q == RESP);
  assign err           = (state_q == RESP) && (code_q != 2'd0);
  assign err_code      = code_q;
  assign load_rdata    = rdata_q;
  assign mem.mem_req   = (state_q == BUS);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// -----------------------------------------------------------------------------
// tb_lsu_data_port
//
// Directed bench for lsu_data_port. Each op pushes its expected outcome to a
// scoreboard queue; bus-phase cycles are compared against the queue head and
// the entry is popped and compared when done pulses. Built with
// LSU_TIMEOUT_EN the watchdog is exercised with TIMEOUT_CYCLES=4; without it
// the bench checks that a long wait completes without a timeout.
// -----------------------------------------------------------------------------
module tb_lsu_data_port;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    int          nreq;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        done;
  logic [31:0] load_rdata;
  logic        err;
  logic [1:0]  err_code;

  int   total;
  int   passed;
  exp_t sb[$];

  lsu_data_port_if bus ();

  lsu_data_port #(
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem        (bus),
    .done       (done),
    .load_rdata (load_rdata),
    .err        (err),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
  endtask

  task automatic do_op(input string tag, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd,
                       input int waits, input logic [1:0] e_code,
                       input logic [31:0] e_rdata, input logic [31:0] e_wdata,
                       input logic [3:0] e_wstrb, input int e_lat, input int e_nreq);
    exp_t e;
    exp_t got;
    int   cyc;
    int   reqs;
    logic seen;
    e.code  = e_code;
    e.rdata = e_rdata;
    e.we    = st;
    e.maddr = {a[31:2], 2'b00};
    e.wdata = e_wdata;
    e.wstrb = e_wstrb;
    e.lat   = e_lat;
    e.nreq  = e_nreq;
    sb.push_back(e);

    @(negedge clk);
    req_valid     = 1'b1;
    is_load       = ld;
    is_store      = st;
    funct3        = f3;
    addr          = a;
    store_data    = d;
    bus.mem_rdata = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;

    cyc  = 0;
    reqs = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req) begin
        chk({tag, "_we_strb"}, {27'd0, bus.mem_we, bus.mem_wstrb}, {27'd0, sb[0].we, sb[0].wstrb});
        chk({tag, "_maddr"}, bus.mem_addr, sb[0].maddr);
        chk({tag, "_wdata"}, bus.mem_wdata, sb[0].wdata);
        bus.mem_ack = (waits >= 0) && (reqs == waits);
        reqs++;
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        got  = sb.pop_front();
        chk({tag, "_latency"}, cyc, got.lat);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, (got.code != 2'd0)});
        chk({tag, "_err_code"}, {30'd0, err_code}, {30'd0, got.code});
        chk({tag, "_load_rdata"}, load_rdata, got.rdata);
        chk({tag, "_ready_in_done"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_bus_cycles"}, reqs, got.nreq);
      end
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {30'd0, done, err}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    $display("op %s f3=%03b addr=0x%08h code=%0d rdata=0x%08h", tag, f3, a, err_code, load_rdata);
  endtask

  initial begin
    total         = 0;
    passed        = 0;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    is_load       = 1'b0;
    is_store      = 1'b0;
    funct3        = 3'b000;
    addr          = 32'd0;
    store_data    = 32'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;

    // Reset state.
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_flags", {28'd0, bus.mem_req, bus.mem_we, done, err}, 32'd0);
    chk("rst_maddr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_wstrb_code", {26'd0, bus.mem_wstrb, err_code}, 32'd0);
    chk("rst_load_rdata", load_rdata, 32'd0);
    $display("reset checked");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Test-plan ops.
    do_op("LB",  1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0,
          2'd0, 32'hFFFF_FF80, 32'h0, 4'b0000, 2, 1);
    do_op("LHU", 1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 3,
          2'd0, 32'h0000_8001, 32'h0, 4'b0000, 5, 4);
    do_op("SH",  0, 1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 0,
          2'd0, 32'h0, 32'hABCD_ABCD, 4'b1100, 2, 1);
    do_op("LW_mis", 1, 0, 3'b010, 32'h0000_4001, 32'h0, 32'h0, 0,
          2'd1, 32'h0, 32'h0, 4'b0000, 1, 0);
    do_op("L011", 1, 0, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 0,
          2'd2, 32'h0, 32'h0, 4'b0000, 1, 0);

    // Additional lanes, extensions and fault corners.
    do_op("LH",  1, 0, 3'b001, 32'h0000_2000, 32'h0, 32'h1111_F00D, 1,
          2'd0, 32'hFFFF_F00D, 32'h0, 4'b0000, 3, 2);
    do_op("LBU", 1, 0, 3'b100, 32'h0000_1001, 32'h0, 32'h1234_8056, 0,
          2'd0, 32'h0000_0080, 32'h0, 4'b0000, 2, 1);
    do_op("SB",  0, 1, 3'b000, 32'h0000_6001, 32'h7777_77A5, 32'h0, 0,
          2'd0, 32'h0, 32'hA5A5_A5A5, 4'b0010, 2, 1);
    do_op("SW",  0, 1, 3'b010, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0, 2,
          2'd0, 32'h0, 32'hDEAD_BEEF, 4'b1111, 4, 3);
    do_op("S100", 0, 1, 3'b100, 32'h0000_7000, 32'h0, 32'h0, 0,
          2'd2, 32'h0, 32'h0, 4'b0000, 1, 0);
    do_op("LHU_mis", 1, 0, 3'b101, 32'h0000_2001, 32'h0, 32'h0, 0,
          2'd1, 32'h0, 32'h0, 4'b0000, 1, 0);

    // A request with neither op flag is ignored.
    @(negedge clk);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ignored_state", {29'd0, req_ready, bus.mem_req, done}, 32'd4);
    @(negedge clk);
    chk("ignored_state2", {29'd0, req_ready, bus.mem_req, done}, 32'd4);
    $display("op IGNORED ready=%0b mem_req=%0b", req_ready, bus.mem_req);

`ifdef LSU_TIMEOUT_EN
    do_op("LW_to", 1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, -1,
          2'd3, 32'h0, 32'h0, 4'b0000, 5, 4);
`else
    do_op("LW_wait", 1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_0001, 10,
          2'd0, 32'hCAFE_0001, 32'h0, 4'b0000, 12, 11);
`endif

    // Reset in the middle of a bus access.
    @(negedge clk);
    req_valid = 1'b1;
    is_load   = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h0000_8000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    is_load   = 1'b0;
    @(negedge clk);
    chk("midrst_req_before", {31'd0, bus.mem_req}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_done_err", {30'd0, done, err}, 32'd0);
    $display("op MIDRST mem_req=%0b ready=%0b", bus.mem_req, req_ready);
    @(negedge clk);
    rst_n = 1'b1;

    // Both flags set: the store wins.
    do_op("SW_post", 1, 1, 3'b010, 32'h0000_9004, 32'h0BAD_F00D, 32'h0, 0,
          2'd0, 32'h0, 32'h0BAD_F00D, 4'b1111, 2, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
